uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 13 +
 rtl/uart_rx_ctrl_baud_gen.sv | 31 +++
 rtl/uart_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: sequencer state encoding
// and the number of oversample ticks that make up one bit period.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } state_t;

    localparam int SB_TICK = 16;

endpackage

// File: rtl/uart_rx_ctrl_baud_gen.sv
// Oversample tick generator: counts 0..divisor and pulses s_tick on the last count.
module uart_baud_gen
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 s_tick
);

    logic [DIV_WIDTH-1:0] count;
    logic                 wrap;

    // >= rather than == so a divisor lowered below the current count wraps at once
    assign wrap   = (count >= divisor);
    assign s_tick = run && wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: line synchronizer, baud tick, idle-line arming sequencer
// for the external uart_rx, and a first-word-fall-through receive FIFO.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int BITWIDTH   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic                          rx_pin,
    output logic                          rx_sync,
    output logic                          s_tick,
    output logic                          rx_rst_n,
    input  logic                          rx_done_tick,
    input  logic [BITWIDTH-1:0]           rx_dout,
    output logic [BITWIDTH-1:0]           m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(SB_TICK);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SB_TICK - 1);

    logic [1:0]        sync_q;
    state_t            state, state_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;

    logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                push, pop, full, do_write, ovf_set;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_pin};
        end
    end

    assign rx_sync = sync_q[1];

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state != OFF),
        .divisor (divisor),
        .s_tick  (s_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= OFF;
            idle_cnt <= '0;
            rx_rst_n <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            rx_rst_n <= (state_next == RUN);
        end
    end

    // ARM waits for one full bit period of idle line before releasing uart_rx
    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        case (state)
            OFF: begin
                idle_next = '0;
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_next = OFF;
                end else if (s_tick) begin
                    if (!rx_sync) begin
                        idle_next = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_next = RUN;
                    end else begin
                        idle_next = idle_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!enable) state_next = OFF;
            end
            default: state_next = OFF;
        endcase
    end

    assign full     = (fifo_count == FULL_CNT);
    assign m_valid  = (fifo_count != '0);
    assign m_data   = m_valid ? mem[rd_ptr] : '0;
    assign push     = rx_done_tick && (state == RUN);
    assign pop      = m_valid && m_ready;
    assign do_write = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= rx_dout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            overflow <= ovf_set || (overflow && !ovf_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: behavioural model checked every cycle, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_uart_rx_ctrl;

    localparam int BITWIDTH   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 16;
    localparam int SB_TICK    = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 enable = 1'b0;
    logic [DIV_WIDTH-1:0] divisor = 16'd3;
    logic                 rx_pin = 1'b1;
    logic                 rx_sync, s_tick, rx_rst_n;
    logic                 rx_done_tick = 1'b0;
    logic [BITWIDTH-1:0]  rx_dout = '0;
    logic [BITWIDTH-1:0]  m_data;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic                 overflow;
    logic                 ovf_clr = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_rx_ctrl #(
        .BITWIDTH   (BITWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .divisor      (divisor),
        .rx_pin       (rx_pin),
        .rx_sync      (rx_sync),
        .s_tick       (s_tick),
        .rx_rst_n     (rx_rst_n),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model: receiver powered (on), uart_rx released (run), cycles since last tick,
    // consecutive high samples while arming, line delayed two clocks, FIFO as a queue.
    bit                  md_on = 0, md_run = 0, md_ovf = 0;
    bit                  md_p1 = 1, md_p2 = 1;
    int                  md_cnt = 0, md_highs = 0;
    logic [BITWIDTH-1:0] md_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_on = 0; md_run = 0; md_ovf = 0;
            md_p1 = 1; md_p2 = 1;
            md_cnt = 0; md_highs = 0;
            md_q.delete();
        end else begin
            bit tick, push, pop, ovf_set;
            int sz;
            tick    = md_on && (md_cnt >= int'(divisor));
            sz      = md_q.size();
            push    = rx_done_tick && md_run;
            pop     = (sz != 0) && m_ready;
            ovf_set = 0;
            if (pop) void'(md_q.pop_front());
            if (push) begin
                if (sz < FIFO_DEPTH || pop) md_q.push_back(rx_dout);
                else ovf_set = 1;
            end
            md_ovf = ovf_set || (md_ovf && !ovf_clr);
            if (!md_on) begin
                md_cnt = 0;
                if (enable) begin
                    md_on = 1;
                    md_highs = 0;
                end
            end else if (!enable) begin
                md_on = 0; md_run = 0; md_cnt = 0;
            end else begin
                md_cnt = tick ? 0 : md_cnt + 1;
                if (!md_run && tick) begin
                    if (!md_p2) md_highs = 0;
                    else if (md_highs == SB_TICK - 1) md_run = 1;
                    else md_highs++;
                end
            end
            md_p2 = md_p1;
            md_p1 = rx_pin;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rx_sync", rx_sync, md_p2);
            chk("s_tick", s_tick, md_on && (md_cnt >= int'(divisor)));
            chk("rx_rst_n", rx_rst_n, md_run);
            chk("m_valid", m_valid, md_q.size() != 0);
            chk("m_data", m_data, (md_q.size() != 0) ? md_q[0] : '0);
            chk("overflow", overflow, md_ovf);
            chk("fifo_count", fifo_count, md_q.size());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!s_tick && cycles < limit);
        chk("tick_seen", s_tick, 1);
    endtask

    task automatic wait_run(input int limit);
        int c = 0;
        while (!rx_rst_n && c < limit) begin
            step();
            c++;
        end
        chk("run_reached", rx_rst_n, 1);
    endtask

    task automatic push_byte(input logic [BITWIDTH-1:0] b);
        rx_dout = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
    endtask

    initial begin
        int c;
        #1 reset_n = 1'b0;
        #1 chk_on = 1'b1;
        step(3);
        chk("rst_rx_sync", rx_sync, 1);
        chk("rst_s_tick", s_tick, 0);
        chk("rst_rx_rst_n", rx_rst_n, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fifo_count", fifo_count, 0);
        reset_n = 1'b1;
        rx_pin = 1'b0;
        step(3);

        // Tick period with divisor 3, then raised to 7 mid-count
        enable = 1'b1;
        wait_tick(20, c);
        wait_tick(20, c);
        chk("period_div3_a", c, 4);
        wait_tick(20, c);
        chk("period_div3_b", c, 4);
        step(2);
        divisor = 16'd7;
        wait_tick(20, c);
        wait_tick(20, c);
        chk("period_div7", c, 8);

        // Low line never arms; 16 high ticks release uart_rx
        for (int i = 0; i < 20; i++) wait_tick(20, c);
        chk("arm_low_line", rx_rst_n, 0);
        divisor = 16'd1;
        rx_pin = 1'b1;
        for (int i = 0; i < 10; i++) wait_tick(4, c);
        chk("arm_partial_idle", rx_rst_n, 0);
        wait_run(100);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rx_done_tick = ($urandom_range(0, 3) == 0);
            rx_dout      = BITWIDTH'($urandom);
            m_ready      = ($urandom_range(0, 2) != 0);
            ovf_clr      = ($urandom_range(0, 15) == 0);
            enable       = ($urandom_range(0, 299) != 0);
            rx_pin       = ($urandom_range(0, 24) != 0);
            if (i % 100 == 0) divisor = DIV_WIDTH'($urandom_range(0, 3));
            step();
        end

        rx_done_tick = 1'b0;
        ovf_clr = 1'b0;
        enable = 1'b1;
        rx_pin = 1'b1;
        divisor = '0;
        m_ready = 1'b1;
        wait_run(100);
        step(6);
        chk("drained", fifo_count, 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Single frame
        m_ready = 1'b0;
        push_byte(8'hA5);
        chk("a5_valid", m_valid, 1);
        chk("a5_data", m_data, 8'hA5);
        chk("a5_count", fifo_count, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("a5_popped", fifo_count, 0);

        // Five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            push_byte(BITWIDTH'(i));
            step();
        end
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_data", m_data, i);
            step();
        end
        m_ready = 1'b0;
        chk("ovf_empty", fifo_count, 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) push_byte(BITWIDTH'(8'h10 + i));
        chk("full_count", fifo_count, 4);
        rx_dout = 8'h14;
        rx_done_tick = 1'b1;
        m_ready = 1'b1;
        step();
        rx_done_tick = 1'b0;
        m_ready = 1'b0;
        chk("pp_count", fifo_count, 4);
        chk("pp_overflow", overflow, 0);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("pp_order", m_data, 8'h10 + i);
            step();
        end
        m_ready = 1'b0;

        // Reset mid-frame with two entries buffered
        push_byte(8'h31);
        push_byte(8'h32);
        chk("pre_rst_count", fifo_count, 2);
        rx_pin = 1'b0;
        step(3);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_rx_sync", rx_sync, 1);
        chk("mid_rst_s_tick", s_tick, 0);
        chk("mid_rst_rx_rst_n", rx_rst_n, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_count", fifo_count, 0);
        rx_pin = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(3);
        chk("rearm_held", rx_rst_n, 0);
        wait_run(100);
        chk("rearm_empty", fifo_count, 0);
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
